// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver for an MM:SS display.
// The divided scan and blink clocks are sampled as ordinary level inputs and
// rise-detected against clk; the display outputs are fully registered.
module seg7_scan_driver #(
  parameter bit LEADING_ZERO   = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_faster,
  input  logic       clk_blink,
  input  logic       adjust,
  input  logic       sel,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [3:0] an,
  output logic [6:0] seg
);

  // Active-low encodings; polarity is applied only at the output register.
  localparam logic [3:0] AnOff   = 4'b1111;
  localparam logic [6:0] SegOff  = 7'b1111111;
  localparam logic [6:0] SegDash = 7'b0111111;
  localparam logic [3:0] AnRst   = SEG_ACTIVE_LOW ? AnOff : ~AnOff;
  localparam logic [6:0] SegRst  = SEG_ACTIVE_LOW ? SegOff : ~SegOff;

  logic       faster_q, blink_q;
  logic       rise_f, rise_b;
  logic [1:0] scan_idx_q, scan_idx_d;
  logic       blink_phase_q, blink_phase_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;

  logic       field_is_min;
  logic [5:0] field_val;
  logic [5:0] tens_full, ones_full;
  logic [3:0] digit;
  logic [6:0] seg_lo;
  logic [3:0] an_lo;
  logic       blank;

  // Rising-edge pulses of the divided clocks; a level already high right
  // after reset counts as a rise because the history registers reset to 0.
  always_comb begin
    rise_f = clk_faster & ~faster_q;
    rise_b = clk_blink & ~blink_q;
  end

  // Scan position and blink phase advance independently on their rises.
  always_comb begin
    scan_idx_d    = scan_idx_q;
    blink_phase_d = blink_phase_q;
    if (rise_f) scan_idx_d = scan_idx_q + 2'd1;
    if (rise_b) blink_phase_d = ~blink_phase_q;
  end

  // Select the digit for the current scan position and decode it.
  always_comb begin
    field_is_min = scan_idx_q[1];
    field_val    = field_is_min ? minutes : seconds;
    tens_full    = field_val / 6'd10;
    ones_full    = field_val % 6'd10;
    digit        = scan_idx_q[0] ? tens_full[3:0] : ones_full[3:0];

    unique case (digit)
      4'd0:    seg_lo = 7'b1000000;
      4'd1:    seg_lo = 7'b1111001;
      4'd2:    seg_lo = 7'b0100100;
      4'd3:    seg_lo = 7'b0110000;
      4'd4:    seg_lo = 7'b0011001;
      4'd5:    seg_lo = 7'b0010010;
      4'd6:    seg_lo = 7'b0000010;
      4'd7:    seg_lo = 7'b1111000;
      4'd8:    seg_lo = 7'b0000000;
      4'd9:    seg_lo = 7'b0010000;
      default: seg_lo = SegDash;
    endcase
    // Out-of-range values show a dash on both digits of the field.
    if (field_val > 6'd59) seg_lo = SegDash;

    an_lo = ~(4'b0001 << scan_idx_q);

    // Flash the selected field in adjust mode; optionally suppress a
    // leading zero on the minutes-tens digit.
    blank = (adjust && blink_phase_q && (field_is_min == ~sel)) ||
            (!LEADING_ZERO && (scan_idx_q == 2'd3) && (minutes < 6'd10));
    if (blank) begin
      an_lo  = AnOff;
      seg_lo = SegOff;
    end

    an_d  = SEG_ACTIVE_LOW ? an_lo : ~an_lo;
    seg_d = SEG_ACTIVE_LOW ? seg_lo : ~seg_lo;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      faster_q      <= 1'b0;
      blink_q       <= 1'b0;
      scan_idx_q    <= 2'd0;
      blink_phase_q <= 1'b0;
      an_q          <= AnRst;
      seg_q         <= SegRst;
    end else begin
      faster_q      <= clk_faster;
      blink_q       <= clk_blink;
      scan_idx_q    <= scan_idx_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus randomized traffic,
// checked against a behavioural model of the MM:SS display. Two instances
// cover both parameter corners (default, and no-leading-zero active-high).
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_faster = 1'b0;
  logic       clk_blink = 1'b0;
  logic       adjust = 1'b0;
  logic       sel = 1'b0;
  logic [5:0] minutes = 6'd0;
  logic [5:0] seconds = 6'd0;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;

  int checks = 0;
  int errors = 0;

  // Model state: digit position, blink phase, previous divided-clock levels.
  int m_idx = 0;
  bit m_ph = 0;
  bit m_pf = 0;
  bit m_pb = 0;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  seg7_scan_driver #(.LEADING_ZERO(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .clk_faster(clk_faster), .clk_blink(clk_blink),
    .adjust(adjust), .sel(sel), .minutes(minutes), .seconds(seconds),
    .an(an_a), .seg(seg_a)
  );

  seg7_scan_driver #(.LEADING_ZERO(1'b0), .SEG_ACTIVE_LOW(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .clk_faster(clk_faster), .clk_blink(clk_blink),
    .adjust(adjust), .sel(sel), .minutes(minutes), .seconds(seconds),
    .an(an_b), .seg(seg_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  // Active-low {an, seg} the display should show for a digit position.
  function automatic logic [10:0] ref_out(input int idx, input bit ph, input bit lz);
    int value;
    int dig;
    bit is_min;
    bit blank;
    logic [3:0] a;
    logic [6:0] s;
    is_min = (idx >= 2);
    value  = is_min ? int'(minutes) : int'(seconds);
    dig    = (idx % 2 == 1) ? value / 10 : value % 10;
    blank  = (adjust && ph && (sel ? !is_min : is_min)) ||
             (!lz && idx == 3 && minutes < 10);
    if (blank) return 11'h7FF;
    a = 4'hF;
    a[idx] = 1'b0;
    s = (value > 59) ? 7'b0111111 : seg_tbl[dig];
    return {a, s};
  endfunction

  // One clock: predict, advance the model, then compare both instances.
  task automatic step();
    logic [10:0] na, nb;
    if (rst) begin
      na = 11'h7FF;
      nb = 11'h000;
    end else begin
      na = ref_out(m_idx, m_ph, 1'b1);
      nb = ~ref_out(m_idx, m_ph, 1'b0);
    end
    @(posedge clk);
    if (rst) begin
      m_idx = 0; m_ph = 0; m_pf = 0; m_pb = 0;
    end else begin
      if (clk_faster && !m_pf) m_idx = (m_idx + 1) % 4;
      if (clk_blink && !m_pb) m_ph = !m_ph;
      m_pf = clk_faster;
      m_pb = clk_blink;
    end
    #1;
    check("model_a", {an_a, seg_a}, na);
    check("model_b", {an_b, seg_b}, nb);
  endtask

  task automatic pulse_f();
    clk_faster = 1'b1; step();
    clk_faster = 1'b0; step();
  endtask

  task automatic pulse_b();
    clk_blink = 1'b1; step();
    clk_blink = 1'b0; step();
  endtask

  initial begin
    // Reset
    rst = 1'b1; step(); step();
    check("rst_a", {an_a, seg_a}, 11'b1111_1111111);
    check("rst_b", {an_b, seg_b}, 11'b0000_0000000);

    // Scan 12:34
    rst = 1'b0; minutes = 6'd12; seconds = 6'd34; step();
    check("scan0", {an_a, seg_a}, 11'b1110_0011001);
    pulse_f(); check("scan1", {an_a, seg_a}, 11'b1101_0110000);
    pulse_f(); check("scan2", {an_a, seg_a}, 11'b1011_0100100);
    pulse_f(); check("scan3", {an_a, seg_a}, 11'b0111_1111001);
    pulse_f(); check("wrap", {an_a, seg_a}, 11'b1110_0011001);

    // Held-high scan clock advances once
    clk_faster = 1'b1; step();
    check("hold_t", {an_a, seg_a}, 11'b1110_0011001);
    step();
    check("hold_t1", {an_a, seg_a}, 11'b1101_0110000);
    repeat (8) step();
    check("hold_end", {an_a, seg_a}, 11'b1101_0110000);
    clk_faster = 1'b0; step();

    // Flash seconds (idx1 now)
    adjust = 1'b1; sel = 1'b1; pulse_b();
    check("blk_s1", {an_a, seg_a}, 11'b1111_1111111);
    pulse_f(); check("blk_m2", {an_a, seg_a}, 11'b1011_0100100);
    pulse_f(); check("blk_m3", {an_a, seg_a}, 11'b0111_1111001);
    pulse_f(); check("blk_s0", {an_a, seg_a}, 11'b1111_1111111);
    pulse_b(); check("blk_off", {an_a, seg_a}, 11'b1110_0011001);
    // Flash minutes
    sel = 1'b0; pulse_b();
    check("blk_sel0_s", {an_a, seg_a}, 11'b1110_0011001);
    pulse_f(); pulse_f();
    check("blk_sel0_m", {an_a, seg_a}, 11'b1111_1111111);
    pulse_b(); adjust = 1'b0;

    // Out-of-range minutes (idx2 now)
    minutes = 6'd63; seconds = 6'd5; step();
    check("dash2", {an_a, seg_a}, 11'b1011_0111111);
    pulse_f(); check("dash3", {an_a, seg_a}, 11'b0111_0111111);
    pulse_f(); check("sec5", {an_a, seg_a}, 11'b1110_0010010);
    pulse_f(); check("sec0", {an_a, seg_a}, 11'b1101_1000000);

    // Leading zero handling at idx3
    minutes = 6'd7; pulse_f(); pulse_f();
    check("lz_on", {an_a, seg_a}, 11'b0111_1000000);
    check("lz_off", {an_b, seg_b}, 11'b0000_0000000);

    // Reset mid-scan at idx2 with blink phase set
    pulse_f(); pulse_f(); pulse_f();
    adjust = 1'b1; sel = 1'b1; pulse_b();
    rst = 1'b1; step();
    check("rst_mid", {an_a, seg_a}, 11'b1111_1111111);
    rst = 1'b0; step();
    check("rst_idx0", {an_a, seg_a}, 11'b1110_0010010);
    pulse_f(); check("rst_idx1", {an_a, seg_a}, 11'b1101_1000000);

    // Simultaneous rises: idx2 becomes current and minutes flash on
    sel = 1'b0; clk_faster = 1'b1; clk_blink = 1'b1; step();
    clk_faster = 1'b0; clk_blink = 1'b0; step();
    check("simul", {an_a, seg_a}, 11'b1111_1111111);

    // Level already high on the first cycle after reset
    adjust = 1'b0; rst = 1'b1; clk_faster = 1'b1; step();
    rst = 1'b0; step(); step();
    check("hi_after_rst", {an_a, seg_a}, 11'b1101_1000000);
    clk_faster = 1'b0; step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 2) == 0) clk_faster = ~clk_faster;
      if ($urandom_range(0, 7) == 0) clk_blink = ~clk_blink;
      if ($urandom_range(0, 15) == 0) adjust = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) sel = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0) minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 31) == 0) seconds = 6'($urandom_range(0, 63));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
